mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Shared sequential shift-add multiplier with a two-requester round-robin front end. It lets two pipeline clients, such as the MULT path and an address/scale helper, use one unsigned W×W multiplier engine. The block grants one request at a time and sequences the engine through the load / add / shift / done steps. It returns a 2W-bit product tagged with the requester id.

## Interface
- `W`, default 16: operand width in bits. Must be ≥ 2.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0`  in  1  requester 0 wants a multiply; held until `gnt0`.
- `a0`, `b0`  in  W each  requester 0 multiplicand and multiplier; stable while `req0` is high.
- `req1`  in  1  requester 1 request; same rules as `req0`.
- `a1`, `b1`  in  W each  requester 1 operands.
- `gnt0`, `gnt1`  out  1 each  accept pulse; operands are captured at the edge ending this cycle.
- `busy`  out  1  engine is occupied (state ≠ IDLE).
- `done`  out  1  one-cycle pulse; `product` and `done_id` are valid.
- `done_id`  out  1  requester whose result is on `product`.
- `product`  out  2W  unsigned a×b; holds its value until the next `done`.

## Operation
- States:
  - IDLE: waits for a request; loads operands on grant.
  - TEST: add step when the multiplier LSB is 1.
  - SHIFT: shifts the accumulator and counts.
  - DONE: publishes the result.
- Registers:
  - `mcand` (W).
  - `acc_hi` (W+1, including carry).
  - `acc_lo` (W).
  - `cnt`, ceil(log2 W) bits.
  - `last_id` (1).
- IDLE:
  - `gnt0`/`gnt1` are combinational from state and reqs. At most one is high; both are low outside IDLE.
  - Only `req0`: grant 0. Only `req1`: grant 1.
  - Both: grant the id ≠ `last_id`.
  - On grant:
    - `mcand` ← a.
    - `acc_lo` ← b.
    - `acc_hi` ← 0.
    - `cnt` ← 0.
    - `last_id` ← granted id.
    - Go to TEST.
  - No request: stay in IDLE.
- TEST: if `acc_lo[0]`, `acc_hi` ← `acc_hi[W-1:0]` + `mcand` (W+1-bit result, carry kept); otherwise hold. Go to SHIFT.
- SHIFT:
  - {`acc_hi`,`acc_lo`} ← {`acc_hi`,`acc_lo`} >> 1, with zero fill into the MSB.
  - If `cnt` = W-1, go to DONE. Otherwise `cnt`+1 and go to TEST.
- DONE:
  - `done` = 1.
  - `product` ← {`acc_hi[W-1:0]`,`acc_lo`}.
  - `done_id` ← `last_id`.
  - Go to IDLE.
- The product is exact for all unsigned inputs; no overflow is possible in 2W bits.
- Requests arriving while `busy` are neither granted nor lost; they wait, held by the requester.

## Timing
- Grant in cycle T, then:
  - TEST/SHIFT alternate over cycles T+1 … T+2W.
  - DONE in cycle T+2W+1, with `done`, `product` and `done_id` registered and visible in that cycle.
  - IDLE at T+2W+2, where a new grant is possible in the same cycle.
- Throughput: one multiply per 2W+2 cycles.
- `busy` is 1 from T+1 through T+2W+1 inclusive.
- Reset values:
  - state = IDLE.
  - `busy` = 0, `done` = 0, `gnt0` = `gnt1` = 0.
  - `done_id` = 0, `product` = 0.
  - `last_id` = 1, so requester 0 wins the first tie.
  - `cnt` = 0 and accumulators = 0.
- Reset mid-operation: the operation is abandoned. No `done` is produced, and all registers take their reset values in the next cycle.
- `rst` overrides any grant in the same cycle: no `gnt` while `rst` = 1.
- A requester may drop `req` in its `gnt` cycle. A `req` still high after `gnt` is a new request.

## Test plan
- W=8, `req0`, a0=13, b0=11 after reset → `gnt0` in cycle T; `done`=1 at T+17 with `product`=143 and `done_id`=0; `busy` high T+1…T+17.
- W=8, a1=255, b1=255 via `req1` → `product`=65025 (0xFE01), `done_id`=1; checks the carry path of `acc_hi`.
- W=8, a0=0, b0=200 → `product`=0. W=8, a0=200, b0=0 → `product`=0. Latency is 17 cycles in both cases (fixed, independent of data).
- Simultaneous requests:
  - Setup: `req0` and `req1` held continuously from reset, with (3,5) and (7,9).
  - Grants: `gnt0` first. `gnt1` in the IDLE cycle right after `done`=1 (15, id0). Then `gnt0` again.
  - Results: 63 with id1.
- `req1` raised mid-operation at T+5 → no `gnt1` until T+18 (IDLE). The first result (id0) is unaffected.
- `rst` pulsed at T+6 of a 13×11 operation → no `done` afterward. `busy`=0, `product`=0, state IDLE the next cycle. A following `req0`/`req1` tie grants 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Two-requester round-robin front end feeding one shared unsigned W x W
//   shift-add multiplier. One request is accepted at a time. The result is
//   returned as a 2W-bit product, tagged with the id of the requester.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; operands loaded on the grant edge
//   TEST  | add mcand into the upper accumulator when multiplier LSB=1
//   SHIFT | shift {acc_hi,acc_lo} right one bit, advance bit counter
//   DONE  | result presented on product/done_id, done pulses
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req0, a0, b0        requester 0 request and operands
//   req1, a1, b1        requester 1 request and operands
//   gnt0, gnt1          combinational accept pulses (IDLE only)
//   busy                engine occupied (state != IDLE)
//   done                one-cycle result-valid pulse
//   done_id             requester owning the result on product
//   product             2W-bit unsigned product, held until next done
module mul_share_arbiter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic           req1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           busy,
    output logic           done,
    output logic           done_id,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, TEST, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mcand;
    logic [W:0]     acc_hi;
    logic [W-1:0]   acc_lo;
    logic [CW-1:0]  cnt;
    logic           last_id;
    logic           last_bit;
    logic [2*W:0]   shifted;

    assign last_bit = (cnt == CW'(W - 1));
    // Right shift of the full {acc_hi,acc_lo} with zero fill at the top.
    assign shifted  = {1'b0, acc_hi, acc_lo[W-1:1]};

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    // On a tie, grant the requester that was not served last.
                    if (req0 && (!req1 || last_id)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0 || gnt1) begin
                    state_d = TEST;
                end
            end
            TEST:    state_d = SHIFT;
            SHIFT:   state_d = last_bit ? DONE : TEST;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            last_id <= 1'b1;
            done_id <= 1'b0;
            product <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        mcand   <= gnt0 ? a0 : a1;
                        acc_lo  <= gnt0 ? b0 : b1;
                        acc_hi  <= '0;
                        cnt     <= '0;
                        last_id <= gnt1;
                    end
                end
                TEST: begin
                    if (acc_lo[0]) begin
                        acc_hi <= {1'b0, acc_hi[W-1:0]} + {1'b0, mcand};
                    end
                end
                SHIFT: begin
                    acc_hi <= shifted[2*W:W];
                    acc_lo <= shifted[W-1:0];
                    // The result is captured on the final shift so it is
                    // already visible during the DONE cycle.
                    if (last_bit) begin
                        product <= shifted[2*W-1:0];
                        done_id <= last_id;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Directed bench for mul_share_arbiter at W=8. Expected values are
//   hand-computed constants. Outputs are sampled 1 ns after the falling edge.
module tb_mul_share_arbiter;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, busy, done, done_id;
    logic [2*W-1:0] product;

    int n_cmp;
    int n_bad;

    mul_share_arbiter #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Steps cycle by cycle from the grant cycle until done (bounded).
    // Requests are dropped after the grant edge unless keep is set.
    task automatic wait_done(input bit keep, output int lat, output bit busy_all);
        lat      = 0;
        busy_all = 1'b1;
        do begin
            @(negedge clk);
            if (!keep && lat == 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            #1;
            lat++;
            if (!busy) busy_all = 1'b0;
        end while (!done && lat < 40);
        if (!done) chk("done_timeout", 32'(lat), 32'd17);
    endtask

    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string tag);
        int lat;
        bit ball;
        if (id) begin
            a1 = a; b1 = b; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; req0 = 1'b1;
        end
        #1;
        chk({tag, "_gnt0"}, 32'(gnt0), 32'(!id));
        chk({tag, "_gnt1"}, 32'(gnt1), 32'(id));
        wait_done(1'b0, lat, ball);
        chk({tag, "_lat"}, 32'(lat), 32'd17);
        chk({tag, "_busy"}, 32'(ball), 32'd1);
        chk({tag, "_prod"}, 32'(product), 32'(exp));
        chk({tag, "_id"}, 32'(done_id), 32'(id));
        @(negedge clk);
        #1;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int lat;
        bit ball;
        bit seen;
        n_cmp = 0;
        n_bad = 0;
        clk  = 1'b0;
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_id", 32'(done_id), 32'd0);
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);

        do_op(1'b0, 8'd13, 8'd11, 16'd143, "m13x11");
        do_op(1'b1, 8'd255, 8'd255, 16'd65025, "m255sq");
        do_op(1'b0, 8'd0, 8'd200, 16'd0, "m0x200");
        do_op(1'b0, 8'd200, 8'd0, 16'd0, "m200x0");

        // Request from 1 arrives mid-operation and must wait for IDLE.
        a0 = 8'd13; b0 = 8'd11; req0 = 1'b1;
        #1;
        chk("mid_gnt0", 32'(gnt0), 32'd1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) req0 = 1'b0;
            if (k == 5) begin
                a1 = 8'd2; b1 = 8'd3; req1 = 1'b1;
            end
            #1;
            if (k >= 5 && gnt1) chk("mid_early_gnt1", 32'(k), 32'd18);
        end
        chk("mid_done", 32'(done), 32'd1);
        chk("mid_prod", 32'(product), 32'd143);
        chk("mid_id", 32'(done_id), 32'd0);
        @(negedge clk);
        #1;
        chk("mid_gnt1", 32'(gnt1), 32'd1);
        wait_done(1'b0, lat, ball);
        chk("mid2_lat", 32'(lat), 32'd17);
        chk("mid2_prod", 32'(product), 32'd6);
        chk("mid2_id", 32'(done_id), 32'd1);
        @(negedge clk);

        // Reset in the middle of an operation abandons it.
        a0 = 8'd13; b0 = 8'd11; req0 = 1'b1;
        #1;
        chk("ra_gnt0", 32'(gnt0), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) req0 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_prod", 32'(product), 32'd0);
        chk("ra_done", 32'(done), 32'd0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("ra_no_done", 32'(seen), 32'd0);
        a0 = 8'd4; b0 = 8'd4; a1 = 8'd1; b1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("ra_tie_gnt0", 32'(gnt0), 32'd1);
        chk("ra_tie_gnt1", 32'(gnt1), 32'd0);
        wait_done(1'b0, lat, ball);
        chk("ra_tie_prod", 32'(product), 32'd16);
        chk("ra_tie_id", 32'(done_id), 32'd0);
        @(negedge clk);

        // Both requests held from reset: 0, then 1, then 0 again.
        rst = 1'b1;
        a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("tie_rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("tie_gnt0", 32'({gnt0, gnt1}), 32'd2);
        wait_done(1'b1, lat, ball);
        chk("tie1_lat", 32'(lat), 32'd17);
        chk("tie1_prod", 32'(product), 32'd15);
        chk("tie1_id", 32'(done_id), 32'd0);
        @(negedge clk);
        #1;
        chk("tie_gnt1", 32'({gnt0, gnt1}), 32'd1);
        wait_done(1'b1, lat, ball);
        chk("tie2_prod", 32'(product), 32'd63);
        chk("tie2_id", 32'(done_id), 32'd1);
        @(negedge clk);
        #1;
        chk("tie_gnt0_again", 32'({gnt0, gnt1}), 32'd2);
        wait_done(1'b0, lat, ball);
        chk("tie3_prod", 32'(product), 32'd15);
        chk("tie3_id", 32'(done_id), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
